trivium_ctrl: RTL and testbench
===============================

# trivium_ctrl

Sequencer for the byte-parallel Trivium keystream core. It accepts an 80-bit key and an 80-bit IV as a byte stream and loads them into the core. It then runs the mandatory 1152-round warm-up, and afterwards releases keystream bytes one at a time to the encryption/FIFO control logic through a valid/read handshake. It sits between the UART/config path and the Trivium core, and is the only block that drives the core's load and step controls.

## Interface

Parameters:
- KEY_BYTES, 10, number of key bytes accepted.
- IV_BYTES, 10, number of IV bytes accepted.
- WARMUP_STEPS, 144, number of core steps in warm-up (8 rounds per step, 1152 rounds total).

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- cfg_data  in  8  key/IV byte.
- cfg_valid  in  1  cfg_data is valid.
- cfg_ready  out  1  controller accepts a byte this cycle.
- cmd_rekey  in  1  abort current activity and restart key/IV load.
- core_key  out  80  key to core; held stable from load onward.
- core_iv  out  80  IV to core; held stable from load onward.
- core_load  out  1  one-cycle pulse that loads key/IV into the core state.
- core_step  out  1  advance the core by 8 rounds this cycle.
- core_byte  in  8  current keystream byte from the core.
- ks_byte  out  8  keystream byte to consumer; equals core_byte when ks_valid is 1, else 0.
- ks_valid  out  1  a fresh keystream byte is available.
- ks_read  in  1  consumer takes ks_byte (counts only when ks_valid is 1).
- busy  out  1  high in every state except READY.

## Operation

States:
- LOAD: cfg_ready=1. Each handshake (cfg_valid & cfg_ready) stores a byte.
  - Byte k, for k < KEY_BYTES, goes to core_key[8k+7:8k].
  - Byte KEY_BYTES+j goes to core_iv[8j+7:8j].
  - The byte counter increments per accepted byte.
  - On the last byte (count = KEY_BYTES+IV_BYTES-1 at accept), go to INIT.
- INIT: core_load=1 for exactly one cycle, then go to WARMUP with the warm-up counter cleared.
- WARMUP: core_step=1 every cycle. The counter increments each cycle. Go to READY when the counter reaches WARMUP_STEPS-1 in the current cycle.
- READY: ks_valid=1. When ks_read=1, go to STEP.
- STEP: core_step=1 and ks_valid=0 for one cycle, then return to READY.
- cmd_rekey, in any state: next state is LOAD, byte counter cleared, key/IV registers cleared. cmd_rekey has priority over ks_read, cfg handshakes and all other transitions in the same cycle. A byte presented in the same cycle as cmd_rekey is not stored.
- cfg_ready is 0 outside LOAD. cfg_valid is ignored outside LOAD.
- ks_read is ignored when ks_valid=0.
- Counter widths:
  - Byte counter is wide enough for KEY_BYTES+IV_BYTES.
  - Warm-up counter is wide enough for WARMUP_STEPS.
  - Neither counter wraps, because each is cleared on state entry.
- core_load and core_step are never high in the same cycle.

## Timing

- Reset (rst high at a clk edge):
  - State becomes LOAD; all counters, core_key and core_iv become 0.
  - core_load=0, core_step=0, ks_valid=0, ks_byte=0.
  - In LOAD after reset: cfg_ready=1, busy=1.
- All outputs are registered or are decoded directly from the state register. There is no combinational path from cfg_valid, ks_read or cmd_rekey to any output.
- Last config byte accepted at edge N:
  - core_load=1 in cycle N+1.
  - core_step=1 in cycles N+2 … N+1+WARMUP_STEPS.
  - ks_valid=1 from cycle N+2+WARMUP_STEPS (N+146 with defaults).
- ks_read=1 while ks_valid=1 at edge M:
  - ks_valid=0 and core_step=1 in cycle M+1.
  - ks_valid=1 again in cycle M+2, with the next byte.
  - Maximum throughput is one byte per 2 cycles.
- Reset mid-operation (any state) takes effect at the next edge, exactly as at power-up.
- cmd_rekey at edge R: cycle R+1 is LOAD, cfg_ready=1, with no core_step or core_load pulse in R+1.

## Test plan

- Reset, then 20 bytes streamed with cfg_valid held high:
  - Required: core_key = bytes 0–9 little-endian, core_iv = bytes 10–19.
  - Required: a single core_load pulse, exactly 144 consecutive core_step cycles, then ks_valid=1.
  - Check cycle counts against the Timing section.
- Config with gaps (cfg_valid toggling 1/0):
  - Required: only handshaken bytes are stored.
  - Required: cfg_ready drops the cycle after the 20th accept.
- In READY, ks_read held high for 6 cycles:
  - Required: exactly 3 reads are accepted and 3 single-cycle core_step pulses occur, alternating ks_valid 1/0.
  - Required: ks_byte=0 whenever ks_valid=0.
- cmd_rekey asserted mid-WARMUP, at step 50:
  - Required: core_step stops next cycle, state is LOAD, core_key and core_iv read 0.
  - Required: a fresh 20-byte load then produces the full 144-step warm-up.
- cmd_rekey and ks_read together in READY:
  - Required: the rekey wins, no core_step pulse occurs, and ks_valid=0 next cycle.
- rst asserted during STEP and during LOAD after 7 bytes:
  - Required: all outputs match their reset values next cycle.
  - Required: the byte counter restarts at 0, so the next 20 bytes form the key/IV.

Source files
------------

// File: rtl/trivium_ctrl_if.sv
// Byte-wide handshake bundle between trivium_ctrl and its neighbours:
// key/IV bytes arrive from the config path, and keystream bytes leave toward
// the encryption/FIFO logic.
interface trivium_ctrl_if;
  logic [7:0] cfg_data;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] ks_byte;
  logic       ks_valid;
  logic       ks_read;

  // Controller side: takes config bytes, offers keystream bytes.
  modport slave (
    input  cfg_data, cfg_valid, ks_read,
    output cfg_ready, ks_byte, ks_valid
  );

  // Peer side: supplies config bytes, consumes keystream bytes.
  modport master (
    output cfg_data, cfg_valid, ks_read,
    input  cfg_ready, ks_byte, ks_valid
  );
endinterface

// File: rtl/trivium_ctrl.sv
// Sequencer for the byte-parallel Trivium core: collects key and IV bytes,
// pulses the core load, runs the warm-up steps, then hands out keystream
// bytes one at a time over a valid/read handshake.
module trivium_ctrl #(
  parameter int unsigned KEY_BYTES    = 10,
  parameter int unsigned IV_BYTES     = 10,
  parameter int unsigned WARMUP_STEPS = 144
) (
  input  logic                   clk,
  input  logic                   rst,
  trivium_ctrl_if.slave          bus,
  input  logic                   cmd_rekey,
  output logic [8*KEY_BYTES-1:0] core_key,
  output logic [8*IV_BYTES-1:0]  core_iv,
  output logic                   core_load,
  output logic                   core_step,
  input  logic [7:0]             core_byte,
  output logic                   busy
);

  localparam int unsigned TOTAL_BYTES = KEY_BYTES + IV_BYTES;
  localparam int unsigned BCW         = $clog2(TOTAL_BYTES + 1);
  localparam int unsigned WCW         = $clog2(WARMUP_STEPS + 1);

  localparam logic [BCW-1:0] LAST_BYTE = BCW'(TOTAL_BYTES - 1);
  localparam logic [WCW-1:0] LAST_STEP = WCW'(WARMUP_STEPS - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_INIT,
    S_WARMUP,
    S_READY,
    S_STEP
  } state_t;

  state_t                 state_q, state_d;
  logic [BCW-1:0]         byte_cnt;
  logic [WCW-1:0]         warm_cnt;
  logic [8*KEY_BYTES-1:0] key_q;
  logic [8*IV_BYTES-1:0]  iv_q;
  logic                   accept;

  // A rekey in the same cycle discards the presented byte.
  assign accept = (state_q == S_LOAD) && bus.cfg_valid && !cmd_rekey;

  // State register; reset and rekey both land in LOAD.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_LOAD;
    else     state_q <= state_d;
  end

  // Next-state decode; rekey overrides every other transition.
  // NOTE: state_d is defaulted first so no path through this block leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (cmd_rekey) begin
      state_d = S_LOAD;
    end else begin
      unique case (state_q)
        S_LOAD:   if (bus.cfg_valid && byte_cnt == LAST_BYTE) state_d = S_INIT;
        S_INIT:   state_d = S_WARMUP;
        S_WARMUP: if (warm_cnt == LAST_STEP) state_d = S_READY;
        S_READY:  if (bus.ks_read) state_d = S_STEP;
        S_STEP:   state_d = S_READY;
        default:  state_d = S_LOAD;
      endcase
    end
  end

  // Byte capture: key bytes first, then IV bytes, little-endian by position.
  always_ff @(posedge clk) begin
    if (rst || cmd_rekey) begin
      byte_cnt <= '0;
      key_q    <= '0;
      iv_q     <= '0;
    end else if (accept) begin
      for (int k = 0; k < int'(KEY_BYTES); k++) begin
        if (byte_cnt == BCW'(k)) key_q[8*k +: 8] <= bus.cfg_data;
      end
      for (int j = 0; j < int'(IV_BYTES); j++) begin
        if (byte_cnt == BCW'(KEY_BYTES + j)) iv_q[8*j +: 8] <= bus.cfg_data;
      end
      byte_cnt <= byte_cnt + BCW'(1);
    end
  end

  // Warm-up step counter; held at zero outside WARMUP so each entry starts fresh.
  always_ff @(posedge clk) begin
    if (rst || state_q != S_WARMUP) warm_cnt <= '0;
    else                            warm_cnt <= warm_cnt + WCW'(1);
  end

  // Outputs decoded purely from the state register (plus the core's byte).
  always_comb begin
    bus.cfg_ready = 1'b0;
    bus.ks_valid  = 1'b0;
    bus.ks_byte   = 8'h00;
    core_load     = 1'b0;
    core_step     = 1'b0;
    busy          = 1'b1;
    unique case (state_q)
      S_LOAD:   bus.cfg_ready = 1'b1;
      S_INIT:   core_load     = 1'b1;
      S_WARMUP: core_step     = 1'b1;
      S_READY: begin
        bus.ks_valid = 1'b1;
        bus.ks_byte  = core_byte;
        busy         = 1'b0;
      end
      S_STEP:   core_step     = 1'b1;
      default:  bus.cfg_ready = 1'b0;
    endcase
  end

  assign core_key = key_q;
  assign core_iv  = iv_q;

endmodule

// File: tb/tb_trivium_ctrl.sv
// Directed bench for trivium_ctrl with a tiny stand-in core whose byte output
// changes by a known amount on every load and step.
module tb_trivium_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_rekey;
  logic [79:0] core_key;
  logic [79:0] core_iv;
  logic        core_load;
  logic        core_step;
  logic [7:0]  core_byte;
  logic        busy;

  trivium_ctrl_if bus ();

  trivium_ctrl #(
    .KEY_BYTES   (10),
    .IV_BYTES    (10),
    .WARMUP_STEPS(144)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .cmd_rekey(cmd_rekey),
    .core_key (core_key),
    .core_iv  (core_iv),
    .core_load(core_load),
    .core_step(core_step),
    .core_byte(core_byte),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Stand-in core: load sets 0xA5, each step adds 59.
  always @(posedge clk) begin
    if (core_load)      core_byte <= 8'hA5;
    else if (core_step) core_byte <= core_byte + 8'd59;
  end

  int n_total = 0;
  int n_pass  = 0;
  int n_steps = 0;

  typedef struct packed {
    logic ks_read;
    logic rekey;
    logic exp_valid;
    logic exp_step;
    logic exp_cfg_ready;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat(input int seed, input int i);
    return 8'(seed + i * 13);
  endfunction

  function automatic logic [79:0] exp_key(input int seed);
    logic [79:0] r;
    for (int k = 0; k < 10; k++) r[8*k +: 8] = pat(seed, k);
    return r;
  endfunction

  function automatic logic [79:0] exp_iv(input int seed);
    logic [79:0] r;
    for (int j = 0; j < 10; j++) r[8*j +: 8] = pat(seed, 10 + j);
    return r;
  endfunction

  function automatic logic [7:0] ks_exp(input int n);
    return 8'(165 + n * 59);
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_cfg_ready"}, 80'(bus.cfg_ready), 80'(1));
    check({tag, "_busy"},      80'(busy),          80'(1));
    check({tag, "_load"},      80'(core_load),     80'(0));
    check({tag, "_step"},      80'(core_step),     80'(0));
    check({tag, "_ks_valid"},  80'(bus.ks_valid),  80'(0));
    check({tag, "_ks_byte"},   80'(bus.ks_byte),   80'(0));
    check({tag, "_key"},       core_key,           80'(0));
    check({tag, "_iv"},        core_iv,            80'(0));
  endtask

  task automatic load_bytes(input int seed, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = pat(seed, i);
      tick();
      if (gaps && i < n - 1) begin
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = 8'hEE;
        tick();
        if (i == 5) check("gap_cfg_ready", 80'(bus.cfg_ready), 80'(1));
      end
    end
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = 8'h00;
  endtask

  // Entered in the core_load cycle; runs until ks_valid or the cycle budget.
  task automatic run_warmup(input string tag);
    int steps = 0;
    int loads = 0;
    int cyc   = 0;
    bit done  = 1'b0;
    while (!done && cyc < 400) begin
      tick();
      cyc++;
      if (core_load) loads++;
      if (core_step) steps++;
      if (bus.ks_valid) done = 1'b1;
    end
    check({tag, "_ks_valid"}, 80'(bus.ks_valid), 80'(1));
    check({tag, "_steps"},    80'(steps),        80'(144));
    check({tag, "_cycles"},   80'(cyc),          80'(145));
    check({tag, "_loads"},    80'(loads),        80'(0));
    n_steps = 144;
    check({tag, "_ks_byte"},  80'(bus.ks_byte),  80'(ks_exp(n_steps)));
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    rst           = 1'b1;
    cmd_rekey     = 1'b0;
    bus.cfg_data  = 8'h00;
    bus.cfg_valid = 1'b0;
    bus.ks_read   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_reset_state("por");

    // Back-to-back load, then full warm-up.
    load_bytes(8'h21, 20, 1'b0);
    check("load1_core_load", 80'(core_load),     80'(1));
    check("load1_cfg_ready", 80'(bus.cfg_ready), 80'(0));
    check("load1_key",       core_key,           exp_key(8'h21));
    check("load1_iv",        core_iv,            exp_iv(8'h21));
    run_warmup("warm1");

    // Held ks_read: alternating READY/STEP, then a rekey colliding with a read.
    for (int r = 0; r < 7; r++) begin
      bus.ks_read = vecs[r].ks_read;
      cmd_rekey   = vecs[r].rekey;
      tick();
      if (core_step) n_steps++;
      check($sformatf("rd%0d_valid", r), 80'(bus.ks_valid),  80'(vecs[r].exp_valid));
      check($sformatf("rd%0d_step", r),  80'(core_step),     80'(vecs[r].exp_step));
      check($sformatf("rd%0d_cfgrdy", r), 80'(bus.cfg_ready), 80'(vecs[r].exp_cfg_ready));
      check($sformatf("rd%0d_busy", r),  80'(busy),          80'(!vecs[r].exp_valid));
      check($sformatf("rd%0d_byte", r),  80'(bus.ks_byte),
            80'(vecs[r].exp_valid ? ks_exp(n_steps) : 8'h00));
    end
    bus.ks_read = 1'b0;
    cmd_rekey   = 1'b0;
    check("rd_total_steps", 80'(n_steps), 80'(147));
    check("rekey_rd_key",   core_key,     80'(0));
    check("rekey_rd_iv",    core_iv,      80'(0));

    // Gapped load; only handshaken bytes land.
    load_bytes(8'h5C, 20, 1'b1);
    check("gap_done_cfg_ready", 80'(bus.cfg_ready), 80'(0));
    check("gap_core_load",      80'(core_load),     80'(1));
    check("gap_key",            core_key,           exp_key(8'h5C));
    check("gap_iv",             core_iv,            exp_iv(8'h5C));

    // Rekey while the warm-up counter reads 50.
    for (int s = 0; s < 51; s++) tick();
    check("mid_warm_step", 80'(core_step), 80'(1));
    cmd_rekey = 1'b1;
    tick();
    cmd_rekey = 1'b0;
    check("rekey_warm_step",  80'(core_step),     80'(0));
    check("rekey_warm_load",  80'(core_load),     80'(0));
    check("rekey_warm_ready", 80'(bus.cfg_ready), 80'(1));
    check("rekey_warm_key",   core_key,           80'(0));
    check("rekey_warm_iv",    core_iv,            80'(0));
    load_bytes(8'h93, 20, 1'b0);
    check("load2_key", core_key, exp_key(8'h93));
    check("load2_iv",  core_iv,  exp_iv(8'h93));
    run_warmup("warm2");

    // Reset while in STEP.
    bus.ks_read = 1'b1;
    tick();
    bus.ks_read = 1'b0;
    check("pre_rst_step", 80'(core_step), 80'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("rst_step");

    // Reset after 7 bytes, then a clean load must start from byte 0.
    load_bytes(8'h47, 7, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_state("rst_load");
    load_bytes(8'hB8, 20, 1'b0);
    check("load3_key", core_key, exp_key(8'hB8));
    check("load3_iv",  core_iv,  exp_iv(8'hB8));
    run_warmup("warm3");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
